add_seq_ctrl: RTL

//   Multi-cycle adder controller: time-shares one 4-bit carry-lookahead slice (add4bit_fast)
//   to add WIDTH-bit operands, one nibble per clock, LSB nibble first.

---
 rtl/add_seq_ctrl_pkg.sv | 11 +
 rtl/add_seq_ctrl_add4bit_fast.sv | 31 +++
 rtl/add_seq_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/add_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package add_seq_ctrl_pkg;

    localparam int NIB = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/add_seq_ctrl_add4bit_fast.sv
// 4-bit carry-lookahead slice: sum nibble plus group generate/propagate for carry chaining.
module add4bit_fast
    import add_seq_ctrl_pkg::*;
(
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    input  logic           ci,
    output logic [NIB-1:0] y,
    output logic           g,
    output logic           p
);

    logic [NIB-1:0] gen;
    logic [NIB-1:0] prop;
    logic           c1, c2, c3;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Every carry is flattened so no ripple path exists inside the slice.
    assign c1 = gen[0] | (prop[0] & ci);
    assign c2 = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & ci);
    assign c3 = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & ci);

    assign y = prop ^ {c3, c2, c1, ci};
    assign g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0]);
    assign p = &prop;

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-cycle adder: one CLA nibble slice reused WIDTH/4 times, LSB nibble first,
// with a start/busy/done handshake and fully registered outputs.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / NIB;
    localparam int CNT_W = $clog2(N);

    state_t             state, state_nx;
    logic [WIDTH-1:0]   a_sh, b_sh;
    logic [CNT_W-1:0]   cnt;
    logic               carry, carry_nx;
    logic               a_msb, b_msb;
    logic               last;
    logic [NIB-1:0]     y;
    logic               g, p;

    add4bit_fast slice (
        .a  (a_sh[NIB-1:0]),
        .b  (b_sh[NIB-1:0]),
        .ci (carry),
        .y  (y),
        .g  (g),
        .p  (p)
    );

    assign carry_nx = g | (p & carry);
    assign last     = (cnt == CNT_W'(N - 1));

    // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (last)  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    sum   <= {y, sum[WIDTH-1:NIB]};
                    carry <= carry_nx;
                    a_sh  <= a_sh >> NIB;
                    b_sh  <= b_sh >> NIB;
                    if (last) begin
                        // a^b^y of the top bit recovers the carry into the MSB.
                        cout <= carry_nx;
                        ovf  <= a_msb ^ b_msb ^ y[NIB-1] ^ carry_nx;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
